// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath: fetch T0-T2, decode,
// then execute steps for ALU, MUL/DIV, NEG/NOT, NOP and HALT, with a memory-wait timeout.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [12:0] alu_op,
  output logic        instr_done,
  output logic        halted,
  output logic        fault,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_ALU3, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
  } op_class_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  op_class_t  op_class;
  logic [12:0] alu_sel;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       unused_ir_bits;

  assign opc = ir[31:27];
  assign ra  = ir[26:23];
  assign rb  = ir[22:19];
  assign rc  = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  function automatic logic [15:0] reg_sel(input logic [3:0] idx);
    reg_sel = 16'd1 << idx;
  endfunction

  // Opcode -> instruction class and one-hot ALU operation (bit0=AND ... bit12=NOT).
  always_comb begin
    op_class = C_ILLEGAL;
    alu_sel  = 13'd0;
    case (opc)
      5'b00011: begin op_class = C_ALU3;   alu_sel = 13'h0004; end // ADD
      5'b00100: begin op_class = C_ALU3;   alu_sel = 13'h0008; end // SUB
      5'b00101: begin op_class = C_ALU3;   alu_sel = 13'h0001; end // AND
      5'b00110: begin op_class = C_ALU3;   alu_sel = 13'h0002; end // OR
      5'b00111: begin op_class = C_ALU3;   alu_sel = 13'h0200; end // ROR
      5'b01000: begin op_class = C_ALU3;   alu_sel = 13'h0400; end // ROL
      5'b01001: begin op_class = C_ALU3;   alu_sel = 13'h0040; end // SHR
      5'b01010: begin op_class = C_ALU3;   alu_sel = 13'h0080; end // SHRA
      5'b01011: begin op_class = C_ALU3;   alu_sel = 13'h0100; end // SHL
      5'b01111: begin op_class = C_MULDIV; alu_sel = 13'h0010; end // MUL
      5'b10000: begin op_class = C_MULDIV; alu_sel = 13'h0020; end // DIV
      5'b10001: begin op_class = C_UNARY;  alu_sel = 13'h0800; end // NEG
      5'b10010: begin op_class = C_UNARY;  alu_sel = 13'h1000; end // NOT
      5'b11010: op_class = C_NOP;
      5'b11011: op_class = C_HALT;
      default:  op_class = C_ILLEGAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output and next-state term gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = 8'd0;
    {Yin, Zin, Zlowout, Zhighout, HIin, LOin} = 6'd0;
    Rout       = 16'd0;
    Rin        = 16'd0;
    alu_op     = 13'd0;
    instr_done = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        {PCout, MARin, IncPC, PCin} = 4'b1111;
        cnt_d   = 8'd0;
        state_d = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_rdy) begin
          cnt_d   = 8'd0;
          state_d = S_T2;
        end else if (32'(cnt_q) + 32'd1 >= MEM_TIMEOUT) begin
          cnt_d   = 8'd0;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (op_class)
          C_ALU3:   begin Rout = reg_sel(rb); Yin = 1'b1; state_d = S_T4; end
          C_MULDIV: begin Rout = reg_sel(ra); Yin = 1'b1; state_d = S_T4; end
          C_UNARY: begin
            Rout = reg_sel(rb); alu_op = alu_sel; Zin = 1'b1; state_d = S_T4;
          end
          C_NOP:   instr_done = 1'b1;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_FAULT;
        endcase
      end
      S_T4: begin
        case (op_class)
          C_ALU3: begin
            Rout = reg_sel(rc); alu_op = alu_sel; Zin = 1'b1; state_d = S_T5;
          end
          C_MULDIV: begin
            Rout = reg_sel(rb); alu_op = alu_sel; Zin = 1'b1; state_d = S_T5;
          end
          C_UNARY: begin Zlowout = 1'b1; Rin = reg_sel(ra); instr_done = 1'b1; end
          default: state_d = S_FAULT;
        endcase
      end
      S_T5: begin
        case (op_class)
          C_ALU3:   begin Zlowout = 1'b1; Rin = reg_sel(ra); instr_done = 1'b1; end
          C_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; state_d = S_T6; end
          default:  state_d = S_FAULT;
        endcase
      end
      S_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_d = S_FAULT;
    endcase

    // run is sampled only at the end of an instruction.
    if (instr_done) state_d = run ? S_T0 : S_IDLE;
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/execute sequences and compares
// every strobe against hand-computed vectors each cycle.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_rdy;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [15:0] Rout, Rin;
  logic [12:0] alu_op;
  logic        instr_done, halted, fault;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                         ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                         ST_HALT = 4'd8, ST_FAULT = 4'd9;
  // fetch field {PCout,MARin,IncPC,PCin,Read,MDRin,MDRout,IRin}
  localparam logic [7:0] F_NONE = 8'h00, F_T0 = 8'hF0, F_T1 = 8'h0C, F_T2 = 8'h03;
  // execute field {Yin,Zin,Zlowout,Zhighout,HIin,LOin}
  localparam logic [5:0] E_NONE = 6'b000000, E_Y = 6'b100000, E_Z = 6'b010000,
                         E_ZLO_RIN = 6'b001000, E_ZLO_LO = 6'b001001, E_ZHI_HI = 6'b000110;

  control_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .instr_done(instr_done),
    .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares the state code and the full packed strobe vector.
  task automatic expect_out(input string tag, input logic [3:0] st, input logic [7:0] f,
                            input logic [5:0] e, input logic [15:0] ro, input logic [15:0] ri,
                            input logic [12:0] alu, input logic d, input logic h,
                            input logic flt);
    logic [63:0] obs, exp;
    obs = {2'b00, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, HIin, LOin, Rout, Rin, alu_op,
           instr_done, halted, fault};
    exp = {2'b00, f, e, ro, ri, alu, d, h, flt};
    check({tag, ".state"}, {60'd0, state}, {60'd0, st});
    check({tag, ".strobes"}, obs, exp);
  endtask

  task automatic expect_fetch();
    expect_out("t0", ST_T0, F_T0, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("t1", ST_T1, F_T1, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("t2", ST_T2, F_T2, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; mem_rdy = 1'b1; ir = 32'h0;
    step(); step();
    expect_out("reset", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    expect_out("idle_norun", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);

    // AND R4,R5,R7 with run held high: back-to-back into MUL.
    run = 1'b1; ir = 32'h2A2B8000;
    step();
    expect_fetch();
    expect_out("and_t3", ST_T3, F_NONE, E_Y, 16'h0020, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("and_t4", ST_T4, F_NONE, E_Z, 16'h0080, 16'h0, 13'h0001, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("and_t5", ST_T5, F_NONE, E_ZLO_RIN, 16'h0, 16'h0010, 13'h0, 1'b1, 1'b0, 1'b0);
    step();

    // MUL R3,R4 (MUL is alu_op bit 4).
    ir = 32'h79A00000;
    expect_fetch();
    expect_out("mul_t3", ST_T3, F_NONE, E_Y, 16'h0008, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("mul_t4", ST_T4, F_NONE, E_Z, 16'h0010, 16'h0, 13'h0010, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("mul_t5", ST_T5, F_NONE, E_ZLO_LO, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    run = 1'b0;
    step();
    expect_out("mul_t6", ST_T6, F_NONE, E_ZHI_HI, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("mul_idle", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("idle_noread", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);

    // NEG R2,R6; run dropped mid-instruction must not truncate it.
    run = 1'b1; ir = {5'b10001, 4'd2, 4'd6, 4'd0, 15'd0};
    step();
    run = 1'b0;
    expect_fetch();
    expect_out("neg_t3", ST_T3, F_NONE, E_Z, 16'h0040, 16'h0, 13'h0800, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("neg_t4", ST_T4, F_NONE, E_ZLO_RIN, 16'h0, 16'h0004, 13'h0, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("neg_idle", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);

    // SUB R0,R0,R0: register 0 is an ordinary one-hot select.
    run = 1'b1; ir = {5'b00100, 27'd0};
    step();
    expect_fetch();
    expect_out("sub0_t3", ST_T3, F_NONE, E_Y, 16'h0001, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("sub0_t4", ST_T4, F_NONE, E_Z, 16'h0001, 16'h0, 13'h0008, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("sub0_t5", ST_T5, F_NONE, E_ZLO_RIN, 16'h0, 16'h0001, 13'h0, 1'b1, 1'b0, 1'b0);
    step();

    // NOP, then a NOP whose fetch waits 3 cycles for memory.
    ir = {5'b11010, 27'd0};
    expect_fetch();
    expect_out("nop_t3", ST_T3, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("nop_t0", ST_T0, F_T0, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    mem_rdy = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      expect_out("wait_t1", ST_T1, F_T1, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    mem_rdy = 1'b1;
    expect_out("wait_t1_rdy", ST_T1, F_T1, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("wait_t2", ST_T2, F_T2, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    run = 1'b0;
    expect_out("wait_nop_t3", ST_T3, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("wait_idle", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);

    // Memory timeout: 15 held cycles in T1, then FAULT.
    run = 1'b1; mem_rdy = 1'b0;
    step();
    expect_out("to_t0", ST_T0, F_T0, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 15; i++) begin
      expect_out("to_t1", ST_T1, F_T1, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("to_fault", ST_FAULT, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b0;
    expect_out("to_reset", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);

    // HALT is sticky until reset.
    run = 1'b1; ir = 32'hD8000000;
    step();
    expect_fetch();
    expect_out("halt_t3", ST_T3, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      expect_out("halted", ST_HALT, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b0;
    expect_out("halt_reset", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);

    // Illegal opcode: FAULT after T3, never any Rin.
    run = 1'b1; ir = 32'hF8000000;
    step();
    expect_fetch();
    expect_out("ill_t3", ST_T3, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      expect_out("ill_fault", ST_FAULT, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;

    // ADD R1,R2,R3 interrupted by reset in T4.
    ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    step();
    expect_fetch();
    expect_out("add_t3", ST_T3, F_NONE, E_Y, 16'h0004, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("add_t4", ST_T4, F_NONE, E_Z, 16'h0008, 16'h0, 13'h0004, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b0;
    expect_out("add_reset", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("final_idle", ST_IDLE, F_NONE, E_NONE, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
